ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
- Ball kinematics engine for the billiard table, the consumer of the collision blocks' outputs.
- Holds each ball's fixed-point position and velocity and integrates velocity into position once per video frame.
- Takes reflected velocities from the border/ball collision logic, loads cue-strike velocities and applies friction decay.
- Feeds ballTopLeftPos/ballVel back to the collision and drawing blocks.

Parameters:
- INIT_X, 11'sd300, reset/top-left X in pixels
- INIT_Y, 11'sd200, reset/top-left Y in pixels
- FRAC_BITS, 6, velocity fraction bits (vel unit = 1/2^FRAC_BITS px/frame)
- FRICTION_PERIOD, 4, frames between friction decrements (>=1)
- COOLDOWN_FRAMES, 3, frames collisions are ignored after one is accepted
- MIN_X, 0 / MAX_X, 608 / MIN_Y, 0 / MAX_Y, 448, position limits (clamp feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- strike  in  1  one-cycle cue-strike pulse
- strikeVelX / strikeVelY  in  11 signed each  strike velocity
- collisionOccurred  in  1  collision block pulse
- ballVelXIn / ballVelYIn  in  11 signed each  post-collision velocity from collision block
- ballTopLeftPosX / ballTopLeftPosY  out  11 signed each  integer pixel position
- ballVelX / ballVelY  out  11 signed each  current velocity
- ballMoving  out  1  high in MOVING state

Behaviour:
- Only clk and reset exist; reset is synchronous, active-high, and overrides everything including mid-motion.
- Reset values: accumulators = INIT_X/INIT_Y << FRAC_BITS; positions INIT_X/INIT_Y; velocities 0; ballMoving 0; state IDLE; friction counter 0; cooldown 0.
- Position accumulators are (11+FRAC_BITS)-bit signed. Output position = accumulator >>> FRAC_BITS (arithmetic), registered.
- Velocity is added sign-extended, and the updated position is visible the cycle after startOfFrame.
- Input velocity of -1024 (strike or collision) saturates to -1023.
- IDLE state:
  - strike with a nonzero velocity: load strikeVel, go to MOVING; ballMoving = 1 next cycle.
  - strike with both components zero: stay IDLE.
  - collisionOccurred and startOfFrame: ignored; position frozen; counters held at 0.
- MOVING state:
  - strike is ignored.
  - collisionOccurred with cooldown == 0: velocities <= ballVelXIn/YIn next cycle; cooldown <= COOLDOWN_FRAMES.
  - collisionOccurred with cooldown > 0: dropped.
  - On startOfFrame: accumulators += current registered velocity; cooldown decrements if > 0; friction counter increments.
  - When the friction counter reaches FRICTION_PERIOD-1, it wraps to 0 and each nonzero velocity component moves 1 toward zero.
  - Velocity becomes (0,0) after any update: go to IDLE, ballMoving = 0 next cycle, friction counter cleared.
- Collision and startOfFrame in the same cycle:
  - Integration uses the old velocity.
  - New velocity = collision input, with no friction that cycle; the friction counter still advances.
  - Cooldown loads COOLDOWN_FRAMES and is not decremented.
  - If the collision velocity is (0,0), go to IDLE.
- Accumulators wrap two's-complement when the feature below is disabled.

Optional Feature:
- BALL_POS_CLAMP_EN defined:
  - After each integration, an integer position below MIN_X is clamped to MIN_X (fraction zeroed) and velX is forced to |velX|.
  - Above MAX_X: clamp to MAX_X and force velX to -|velX|. Y is handled the same way against MIN_Y/MAX_Y.
  - Clamp takes precedence over same-cycle collision velocity for the clamped axis.
- BALL_POS_CLAMP_EN undefined: no clamping logic; wrap-around as above.

Test Plan:
- Reset held 2 cycles during motion -> pos (300,200), vel (0,0), ballMoving 0 the next cycle.
- Strike vel (64,-32), then 4 frames -> pos (304,198); after the 4th frame vel (63,-31); ballMoving 1 throughout.
- MOVING velX=64; collision with ballVelXIn=-64 -> velX=-64 next cycle; a second collision 1 frame later is ignored; a collision after 3 frames is accepted.
- startOfFrame and collision in the same cycle with old velX=64 and new -64 -> X accumulator advances +64, velX=-64, cooldown=3.
- Strike vel (1,0), 4 frames -> vel (0,0), ballMoving 0, state IDLE, pos (300,200); later startOfFrame pulses leave position unchanged.
- BALL_POS_CLAMP_EN with MAX_X=302, strike velX=64, 3 frames -> X=302, velX=-64; without the macro -> X=303, velX=64.

Source files
------------

// File: rtl/ball_motion.sv
`default_nettype none
// ============================================================================
// Module   : ball_motion
// Purpose  : Fixed-point ball kinematics: integration, cue strike, collision
//            response with cooldown, and periodic friction decay.
//            Optional BALL_POS_CLAMP_EN clamps position to table limits.
// Revision : 1.0
// ============================================================================
module ball_motion #(
    parameter logic signed [10:0] INIT_X          = 11'sd300,
    parameter logic signed [10:0] INIT_Y          = 11'sd200,
    parameter int                 FRAC_BITS       = 6,
    parameter int                 FRICTION_PERIOD = 4,
    parameter int                 COOLDOWN_FRAMES = 3
`ifdef BALL_POS_CLAMP_EN
    ,
    parameter logic signed [10:0] MIN_X           = 11'sd0,
    parameter logic signed [10:0] MAX_X           = 11'sd608,
    parameter logic signed [10:0] MIN_Y           = 11'sd0,
    parameter logic signed [10:0] MAX_Y           = 11'sd448
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               strike,
    input  logic signed [10:0] strikeVelX,
    input  logic signed [10:0] strikeVelY,
    input  logic               collisionOccurred,
    input  logic signed [10:0] ballVelXIn,
    input  logic signed [10:0] ballVelYIn,
    output logic signed [10:0] ballTopLeftPosX,
    output logic signed [10:0] ballTopLeftPosY,
    output logic signed [10:0] ballVelX,
    output logic signed [10:0] ballVelY,
    output logic               ballMoving
);

    localparam int c_acc_w = 11 + FRAC_BITS;
    localparam int c_fc_w  = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam int c_cd_w  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [c_fc_w-1:0]         c_fc_last    = c_fc_w'(FRICTION_PERIOD - 1);
    localparam logic [c_cd_w-1:0]         c_cd_load    = c_cd_w'(COOLDOWN_FRAMES);
    localparam logic signed [c_acc_w-1:0] c_acc_init_x = {INIT_X, {FRAC_BITS{1'b0}}};
    localparam logic signed [c_acc_w-1:0] c_acc_init_y = {INIT_Y, {FRAC_BITS{1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    // -1024 has no positive counterpart, so it is pulled in to -1023
    function automatic logic signed [10:0] sat_vel(input logic signed [10:0] v);
        return (v == 11'sh400) ? 11'sh401 : v;
    endfunction

    function automatic logic signed [10:0] toward_zero(input logic signed [10:0] v);
        if (v == 11'sd0) return v;
        else if (v[10])  return v + 11'sd1;
        else             return v - 11'sd1;
    endfunction

    function automatic logic signed [10:0] mag(input logic signed [10:0] v);
        return v[10] ? -v : v;
    endfunction

    state_t                     state_q, state_d;
    logic signed [c_acc_w-1:0]  acc_x_q, acc_x_d;
    logic signed [c_acc_w-1:0]  acc_y_q, acc_y_d;
    logic signed [10:0]         vel_x_q, vel_x_d;
    logic signed [10:0]         vel_y_q, vel_y_d;
    logic [c_fc_w-1:0]          fric_q, fric_d;
    logic [c_cd_w-1:0]          cd_q, cd_d;

    logic signed [10:0]         w_strike_vx, w_strike_vy;
    logic signed [10:0]         w_col_vx, w_col_vy;
    logic                       w_col_ok;
    logic                       w_fric_hit;
`ifdef BALL_POS_CLAMP_EN
    logic signed [10:0]         w_pos_x_new, w_pos_y_new;
    logic signed [10:0]         w_base_vx, w_base_vy;
`endif

    assign w_strike_vx = sat_vel(strikeVelX);
    assign w_strike_vy = sat_vel(strikeVelY);
    assign w_col_vx    = sat_vel(ballVelXIn);
    assign w_col_vy    = sat_vel(ballVelYIn);
    assign w_col_ok    = collisionOccurred && (cd_q == '0) && (state_q == ST_MOVING);
    assign w_fric_hit  = (fric_q == c_fc_last);

    always_comb begin
        state_d = state_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        vel_x_d = vel_x_q;
        vel_y_d = vel_y_q;
        fric_d  = fric_q;
        cd_d    = cd_q;
`ifdef BALL_POS_CLAMP_EN
        w_pos_x_new = '0;
        w_pos_y_new = '0;
        w_base_vx   = '0;
        w_base_vy   = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                fric_d = '0;
                cd_d   = '0;
                if (strike && ((w_strike_vx != 11'sd0) || (w_strike_vy != 11'sd0))) begin
                    vel_x_d = w_strike_vx;
                    vel_y_d = w_strike_vy;
                    state_d = ST_MOVING;
                end
            end

            default: begin
                // Integration always uses the velocity registered before this cycle
                if (startOfFrame) begin
                    acc_x_d = acc_x_q + {{FRAC_BITS{vel_x_q[10]}}, vel_x_q};
                    acc_y_d = acc_y_q + {{FRAC_BITS{vel_y_q[10]}}, vel_y_q};
                    fric_d  = w_fric_hit ? '0 : fric_q + 1'b1;
                    if (!w_col_ok) begin
                        if (w_fric_hit) begin
                            vel_x_d = toward_zero(vel_x_q);
                            vel_y_d = toward_zero(vel_y_q);
                        end
                        if (cd_q != '0) cd_d = cd_q - 1'b1;
                    end
                end

                if (w_col_ok) begin
                    vel_x_d = w_col_vx;
                    vel_y_d = w_col_vy;
                    cd_d    = c_cd_load;
                end

`ifdef BALL_POS_CLAMP_EN
                // A clamped axis ignores any same-cycle collision velocity
                if (startOfFrame) begin
                    w_pos_x_new = acc_x_d[c_acc_w-1:FRAC_BITS];
                    w_pos_y_new = acc_y_d[c_acc_w-1:FRAC_BITS];
                    w_base_vx   = w_col_ok ? vel_x_q : vel_x_d;
                    w_base_vy   = w_col_ok ? vel_y_q : vel_y_d;
                    if (w_pos_x_new < MIN_X) begin
                        acc_x_d = {MIN_X, {FRAC_BITS{1'b0}}};
                        vel_x_d = mag(w_base_vx);
                    end else if (w_pos_x_new > MAX_X) begin
                        acc_x_d = {MAX_X, {FRAC_BITS{1'b0}}};
                        vel_x_d = -mag(w_base_vx);
                    end
                    if (w_pos_y_new < MIN_Y) begin
                        acc_y_d = {MIN_Y, {FRAC_BITS{1'b0}}};
                        vel_y_d = mag(w_base_vy);
                    end else if (w_pos_y_new > MAX_Y) begin
                        acc_y_d = {MAX_Y, {FRAC_BITS{1'b0}}};
                        vel_y_d = -mag(w_base_vy);
                    end
                end
`endif

                if ((vel_x_d == 11'sd0) && (vel_y_d == 11'sd0)) begin
                    state_d = ST_IDLE;
                    fric_d  = '0;
                    cd_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_x_q <= c_acc_init_x;
            acc_y_q <= c_acc_init_y;
            vel_x_q <= '0;
            vel_y_q <= '0;
            fric_q  <= '0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            vel_x_q <= vel_x_d;
            vel_y_q <= vel_y_d;
            fric_q  <= fric_d;
            cd_q    <= cd_d;
        end
    end

    assign ballTopLeftPosX = acc_x_q[c_acc_w-1:FRAC_BITS];
    assign ballTopLeftPosY = acc_y_q[c_acc_w-1:FRAC_BITS];
    assign ballVelX        = vel_x_q;
    assign ballVelY        = vel_y_q;
    assign ballMoving      = (state_q == ST_MOVING);

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_motion
// Purpose  : Self-checking bench for ball_motion: directed scenarios plus a
//            randomized run against an integer reference model.
// Revision : 1.0
// ============================================================================
module tb_ball_motion;

    localparam int FP  = 4;
    localparam int CDF = 3;
    localparam int FB  = 6;
    localparam int MNX = 0;
    localparam int MXX = 302;
    localparam int MNY = 0;
    localparam int MXY = 448;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               strike = 1'b0;
    logic               collisionOccurred = 1'b0;
    logic signed [10:0] strikeVelX = '0, strikeVelY = '0;
    logic signed [10:0] ballVelXIn = '0, ballVelYIn = '0;
    logic signed [10:0] ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY;
    logic               ballMoving;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, accumulators in 1/64 px
    int m_ax = 300 * 64, m_ay = 200 * 64, m_vx = 0, m_vy = 0, m_fc = 0, m_cd = 0;
    bit m_mov = 1'b0;

`ifdef BALL_POS_CLAMP_EN
    ball_motion #(.MAX_X(11'sd302)) dut (
`else
    ball_motion dut (
`endif
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .strike(strike),
        .strikeVelX(strikeVelX), .strikeVelY(strikeVelY),
        .collisionOccurred(collisionOccurred),
        .ballVelXIn(ballVelXIn), .ballVelYIn(ballVelYIn),
        .ballTopLeftPosX(ballTopLeftPosX), .ballTopLeftPosY(ballTopLeftPosY),
        .ballVelX(ballVelX), .ballVelY(ballVelY), .ballMoving(ballMoving)
    );

    function automatic int sat(int v);
        return (v == -1024) ? -1023 : v;
    endfunction

    function automatic int wrap17(int a);
        int r;
        r = a & 32'h1FFFF;
        if (r >= 65536) r -= 131072;
        return r;
    endfunction

    function automatic int mag(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int toward0(int v);
        return (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
    endfunction

    function automatic logic [44:0] pack(int px, int py, int vx, int vy, bit mv);
        return {11'(px), 11'(py), 11'(vx), 11'(vy), mv};
    endfunction

    function automatic logic signed [10:0] rand_vel();
        int k, v;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 11'sd0;
        if (k == 1) return 11'sh400;
        if (k <= 6) begin
            v = int'($urandom_range(0, 12)) - 6;
            return 11'(v);
        end
        return 11'($urandom);
    endfunction

    task automatic model_step();
        int nvx, nvy;
        bit col, hit;
        if (reset) begin
            m_ax = 300 * 64; m_ay = 200 * 64; m_vx = 0; m_vy = 0;
            m_mov = 1'b0; m_fc = 0; m_cd = 0;
            return;
        end
        if (!m_mov) begin
            if (strike && (sat(int'(strikeVelX)) != 0 || sat(int'(strikeVelY)) != 0)) begin
                m_vx = sat(int'(strikeVelX));
                m_vy = sat(int'(strikeVelY));
                m_mov = 1'b1;
            end
            return;
        end
        col = collisionOccurred && (m_cd == 0);
        nvx = m_vx;
        nvy = m_vy;
        if (startOfFrame) begin
            m_ax = wrap17(m_ax + m_vx);
            m_ay = wrap17(m_ay + m_vy);
            hit  = (m_fc == FP - 1);
            m_fc = (m_fc + 1) % FP;
            if (!col) begin
                if (hit) begin
                    nvx = toward0(nvx);
                    nvy = toward0(nvy);
                end
                if (m_cd > 0) m_cd--;
            end
        end
        if (col) begin
            nvx = sat(int'(ballVelXIn));
            nvy = sat(int'(ballVelYIn));
            m_cd = CDF;
        end
`ifdef BALL_POS_CLAMP_EN
        if (startOfFrame) begin
            if ((m_ax >>> FB) < MNX) begin
                m_ax = MNX * 64; nvx = mag(col ? m_vx : nvx);
            end else if ((m_ax >>> FB) > MXX) begin
                m_ax = MXX * 64; nvx = -mag(col ? m_vx : nvx);
            end
            if ((m_ay >>> FB) < MNY) begin
                m_ay = MNY * 64; nvy = mag(col ? m_vy : nvy);
            end else if ((m_ay >>> FB) > MXY) begin
                m_ay = MXY * 64; nvy = -mag(col ? m_vy : nvy);
            end
        end
`endif
        m_vx = nvx;
        m_vy = nvy;
        if (nvx == 0 && nvy == 0) begin
            m_mov = 1'b0; m_fc = 0; m_cd = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        reset = 1'b0; startOfFrame = 1'b0; strike = 1'b0; collisionOccurred = 1'b0;
    endtask

    task automatic do_strike(int vx, int vy);
        strikeVelX = 11'(vx); strikeVelY = 11'(vy); strike = 1'b1;
        tick();
    endtask

    task automatic do_collide(int vx, int vy, bit sof);
        ballVelXIn = 11'(vx); ballVelYIn = 11'(vy); collisionOccurred = 1'b1;
        startOfFrame = sof;
        tick();
    endtask

    task automatic do_frames(int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [44:0] obs, exp;
        do_reset(); do_reset();
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(300, 200, 0, 0, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_initial: got %h expected %h", obs, exp); end
        do_strike(100, 50);
        do_frames(2);
        checks++;
        if (ballMoving !== 1'b1) begin errors++; $display("FAIL reset_premotion: moving=%b expected 1", ballMoving); end
        do_reset(); do_reset();
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_midmotion: got %h expected %h", obs, exp); end
    endtask

    task automatic test_strike_friction();
        logic [44:0] obs, exp;
        do_reset();
        do_strike(64, -32);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(300, 200, 64, -32, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL strike_load: got %h expected %h", obs, exp); end
        for (int i = 0; i < 4; i++) begin
            do_frames(1);
            checks++;
            if (ballMoving !== 1'b1) begin errors++; $display("FAIL strike_moving frame %0d: got %b expected 1", i, ballMoving); end
        end
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(304, 198, 63, -31, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL strike_friction: got %h expected %h", obs, exp); end
    endtask

    task automatic test_saturation();
        logic [44:0] obs, exp;
        do_reset();
        do_strike(0, 0);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(300, 200, 0, 0, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL zero_strike: got %h expected %h", obs, exp); end
        do_strike(-1024, 5);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(300, 200, -1023, 5, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL strike_sat: got %h expected %h", obs, exp); end
        do_collide(3, -1024, 1'b0);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(300, 200, 3, -1023, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL collision_sat: got %h expected %h", obs, exp); end
    endtask

    task automatic test_collision_cooldown();
        logic [44:0] obs, exp;
        do_reset();
        do_strike(64, 0);
        do_collide(-64, 0, 1'b0);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(300, 200, -64, 0, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL collision_accept: got %h expected %h", obs, exp); end
        do_frames(1);
        do_collide(32, 5, 1'b0);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(299, 200, -64, 0, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL collision_cooldown_drop: got %h expected %h", obs, exp); end
        do_frames(2);
        do_collide(32, 5, 1'b0);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(297, 200, 32, 5, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL collision_after_cooldown: got %h expected %h", obs, exp); end
    endtask

    task automatic test_same_cycle();
        logic [44:0] obs, exp;
        do_reset();
        do_strike(64, 0);
        do_collide(-64, 0, 1'b1);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(301, 200, -64, 0, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL same_cycle: got %h expected %h", obs, exp); end
        do_frames(2);
        do_collide(10, 10, 1'b0);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(299, 200, -64, 0, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL same_cycle_cooldown: got %h expected %h", obs, exp); end
    endtask

    task automatic test_stop();
        logic [44:0] obs, exp;
        do_reset();
        do_strike(1, 0);
        do_frames(4);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        exp = pack(300, 200, 0, 0, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stop_idle: got %h expected %h", obs, exp); end
        do_frames(3);
        do_collide(5, 5, 1'b1);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL idle_frozen: got %h expected %h", obs, exp); end
    endtask

    task automatic test_clamp();
        logic [44:0] obs, exp;
        do_reset();
        do_strike(64, 0);
        do_frames(3);
        obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
`ifdef BALL_POS_CLAMP_EN
        exp = pack(302, 200, -64, 0, 1);
`else
        exp = pack(303, 200, 64, 0, 1);
`endif
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL clamp_edge: got %h expected %h", obs, exp); end
    endtask

    task automatic test_random();
        logic [44:0] obs, exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset             = ($urandom_range(0, 299) == 0);
            strike            = ($urandom_range(0, 24) == 0);
            startOfFrame      = ($urandom_range(0, 3) == 0);
            collisionOccurred = ($urandom_range(0, 5) == 0);
            strikeVelX = rand_vel(); strikeVelY = rand_vel();
            ballVelXIn = rand_vel(); ballVelYIn = rand_vel();
            tick();
            obs = {ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY, ballMoving};
            exp = pack(m_ax >>> FB, m_ay >>> FB, m_vx, m_vy, m_mov);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_strike_friction();
        test_saturation();
        test_collision_cooldown();
        test_same_cycle();
        test_stop();
        test_clamp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
